// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter: two-master wishbone arbiter (core, ROM loader) onto the SDRAM port; SDRAM_ARB_PACK_EN packs loader halfwords
module sdram_wb_arbiter #(
  parameter logic [25:0] LD_BASE = 26'h0400000,
  parameter bit LD_EXCLUSIVE = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ld_en,
  input  logic        ld_wr,
  input  logic [23:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_wait,
  input  logic        c_cyc,
  input  logic        c_stb,
  input  logic        c_we,
  input  logic [3:0]  c_sel,
  input  logic [23:0] c_adr,
  input  logic [31:0] c_dat_w,
  input  logic [2:0]  c_cti,
  output logic        c_ack,
  output logic [31:0] c_dat_r,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [3:0]  m_sel,
  output logic [25:0] m_adr,
  output logic [31:0] m_dat_w,
  output logic [2:0]  m_cti,
  input  logic        m_ack,
  input  logic [31:0] m_dat_r,
  output logic [1:0]  gnt
);
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CORE = 2'b01;
  localparam logic [1:0] S_LOAD = 2'b10;
  logic [1:0] state;
  logic pend, take, ld_req, core_g, load_g, unused_bits;
  logic [25:0] h_adr;
  logic [31:0] h_dat, t_dat;
  logic [3:0] h_sel, t_sel;
  logic [21:0] t_wadr;
  assign unused_bits = ld_addr[0];
  assign core_g = state == S_CORE;
  assign load_g = state == S_LOAD;
  assign ld_req = pend | take;
  assign gnt = state;
`ifdef SDRAM_ARB_PACK_EN
  logic b_v, b_hi, acc, same, prom, use_b;
  logic [21:0] b_adr;
  logic [15:0] b_dat;
  assign ld_wait = pend | (b_v & b_hi);
  assign acc = ld_en & ld_wr & ~ld_wait;
  assign same = b_v & (b_adr == ld_addr[23:2]);
  assign prom = ~pend & b_v & (b_hi | ~ld_en);
  assign take = prom | (acc & (b_v | ld_addr[1]));
  assign use_b = prom | (b_v & ~(ld_addr[1] & same));
  assign t_wadr = use_b ? b_adr : ld_addr[23:2];
  assign t_dat = use_b ? {b_dat, b_dat} : same ? {ld_data, b_dat} : {ld_data, ld_data};
  assign t_sel = use_b ? (b_hi ? 4'b1100 : 4'b0011) : same ? 4'b1111 : 4'b1100;
  // pack buffer: holds a low half awaiting its partner, or a high half queued behind a flush
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      b_v <= 1'b0;
      b_hi <= 1'b0;
      b_adr <= '0;
      b_dat <= '0;
    end else if (prom) b_v <= 1'b0;
    else if (acc & ~ld_addr[1]) begin
      b_v <= 1'b1;
      b_hi <= 1'b0;
      b_adr <= ld_addr[23:2];
      b_dat <= ld_data;
    end else if (acc & same) b_v <= 1'b0;
    else if (acc & b_v) begin
      b_hi <= 1'b1;
      b_adr <= ld_addr[23:2];
      b_dat <= ld_data;
    end
`else
  assign ld_wait = pend;
  assign take = ld_en & ld_wr & ~pend;
  assign t_wadr = ld_addr[23:2];
  assign t_dat = {ld_data, ld_data};
  assign t_sel = ld_addr[1] ? 4'b1100 : 4'b0011;
`endif
  // loader holding register: one pending write from capture until its ack
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      pend <= 1'b0;
      h_adr <= '0;
      h_dat <= '0;
      h_sel <= '0;
    end else if (take) begin
      pend <= 1'b1;
      h_adr <= LD_BASE + {2'b00, t_wadr, 2'b00};
      h_dat <= t_dat;
      h_sel <= t_sel;
    end else if (load_g & m_ack) pend <= 1'b0;
  // grant FSM: loader has priority from IDLE, core bursts run to their last beat
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= core_g ? ((~c_cyc | (m_ack & (c_cti == 3'b000 | c_cti == 3'b111))) ? S_IDLE : S_CORE)
                : load_g ? (m_ack ? S_IDLE : S_LOAD)
                : ld_req ? S_LOAD
                : (c_cyc & c_stb & (~LD_EXCLUSIVE | ~ld_en)) ? S_CORE : S_IDLE;
  assign m_cyc = core_g ? c_cyc : load_g;
  assign m_stb = core_g ? c_stb : load_g;
  assign m_we = core_g ? c_we : load_g;
  assign m_sel = core_g ? c_sel : load_g ? h_sel : 4'b0000;
  assign m_adr = core_g ? {c_adr, 2'b00} : load_g ? h_adr : 26'd0;
  assign m_dat_w = core_g ? c_dat_w : load_g ? h_dat : 32'd0;
  assign m_cti = core_g ? c_cti : 3'b000;
  assign c_ack = core_g & m_ack;
  assign c_dat_r = core_g ? m_dat_r : 32'd0;
endmodule
